// File: rtl/if_id_buffer_pkg.sv
// if_id_buffer_pkg: shared instruction-field constants and the buffer entry type
package if_id_buffer_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam int IMM_LSB = 0;
  localparam int IMM_W = 16;
  localparam int TARGET_W = 26;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus_four;
  } entry_t;
endpackage

// File: rtl/if_id_buffer_fifo_mem.sv
// fifo_mem: DEPTH-entry register array, one synchronous write port, one combinational read port
module fifo_mem
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  entry_t        wd,
  input  logic [AW-1:0] ra,
  output entry_t        rd
);
  entry_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode FIFO with valid/ready handshake, flush, and PC-unit field taps
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  in_instr,
  input  logic [INSTR_W-1:0]  in_pc_plus_four,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [INSTR_W-1:0]  out_pc_plus_four,
  output logic [IMM_W-1:0]    out_imm16,
  output logic [TARGET_W-1:0] out_target26,
  output logic [AW:0]         count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic enq, deq;
  entry_t head;
  assign in_ready  = count != FULL;
  assign out_valid = count != '0;
  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !flush;
  fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(enq),
    .wa(wr_ptr),
    .wd('{instr: in_instr, pc_plus_four: in_pc_plus_four}),
    .ra(rd_ptr),
    .rd(head)
  );
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(enq);
      rd_ptr <= rd_ptr + AW'(deq);
      count  <= count + (AW+1)'(enq) - (AW+1)'(deq);
    end
  end
  assign out_instr        = out_valid ? head.instr : NOP_INSTR;
  assign out_pc_plus_four = out_valid ? head.pc_plus_four : '0;
  assign out_imm16        = out_instr[IMM_LSB +: IMM_W];
  assign out_target26     = out_instr[TARGET_W-1:0];
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed plus random stimulus checked against a queue-based reference model
module tb_if_id_buffer;
  import if_id_buffer_pkg::*;
  localparam int DEPTH = 2;
  localparam int AW = 1;
  logic clk = 0, reset = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_pc = 0;
  logic in_ready, out_valid;
  logic [31:0] out_instr, out_pc;
  logic [15:0] out_imm16;
  logic [25:0] out_target26;
  logic [AW:0] count;
  typedef struct {
    logic [31:0] i;
    logic [31:0] p;
  } ent_t;
  ent_t q[$];
  int n_cmp = 0, n_bad = 0;

  if_id_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc_plus_four(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus_four(out_pc), .out_imm16(out_imm16),
    .out_target26(out_target26), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [31:0] ei, ep;
    n  = q.size();
    ei = n > 0 ? q[0].i : 32'h0;
    ep = n > 0 ? q[0].p : 32'h0;
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(n != DEPTH));
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(ei));
    chk({tag, ".out_pc"}, 64'(out_pc), 64'(ep));
    chk({tag, ".imm16"}, 64'(out_imm16), 64'(ei & 32'h0000_ffff));
    chk({tag, ".target26"}, 64'(out_target26), 64'(ei & 32'h03ff_ffff));
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f, input logic rs);
    in_valid = v; in_instr = i; in_pc = p; out_ready = r; flush = f; reset = rs;
  endtask

  task automatic tick(input string tag);
    bit e, d;
    ent_t x;
    x.i = in_instr;
    x.p = in_pc;
    if (reset || flush) q.delete();
    else begin
      e = in_valid && q.size() < DEPTH;
      d = out_ready && q.size() > 0;
      if (d) void'(q.pop_front());
      if (e) q.push_back(x);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    #1;
    drive(1, 32'h2008_0005, 32'h0000_0004, 0, 0, 1);
    tick("reset");
    tick("reset_hold");
    drive(1, 32'h1109_0003, 32'h0000_0004, 0, 0, 0);
    tick("enq1");
    drive(0, 0, 0, 0, 0, 0);
    tick("hold1");
    drive(0, 0, 0, 1, 0, 0);
    tick("drain1");
    drive(1, 32'h0800_0010, 32'h0000_0008, 0, 0, 0);
    tick("enqA");
    drive(1, 32'h0000_0020, 32'h0000_000c, 0, 0, 0);
    tick("enqB");
    drive(1, 32'hdead_beef, 32'h0000_0010, 0, 0, 0);
    tick("enqC_ignored");
    drive(1, 32'hcafe_f00d, 32'h0000_0014, 1, 0, 0);
    tick("full_deq");
    drive(0, 0, 0, 1, 0, 0);
    tick("deqB");
    tick("empty_deq");
    drive(1, 32'h0000_0100, 32'h0000_0100, 0, 0, 0);
    tick("stream_prime");
    for (int k = 1; k <= 8; k++) begin
      drive(1, 32'h0000_0100 + 32'(k), 32'h0000_0100 + 32'(4 * k), 1, 0, 0);
      tick("stream");
    end
    drive(1, 32'h0000_0200, 32'h0000_0200, 0, 0, 0);
    tick("fill2");
    drive(1, 32'h0000_0300, 32'h0000_0300, 1, 1, 0);
    tick("flush");
    drive(0, 0, 0, 1, 0, 0);
    tick("post_flush");
    drive(1, 32'h0000_0400, 32'h0000_0400, 0, 0, 0);
    tick("enq_pre_rst");
    drive(1, 32'h0000_0500, 32'h0000_0500, 1, 1, 1);
    tick("flush_reset");
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      drive($urandom % 4 != 0, $urandom, $urandom, $urandom % 3 != 0,
            $urandom % 16 == 0, $urandom % 40 == 0);
      tick("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
